// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - PLL_CORE control/status bundle between sequencer and PLL
interface pll_lock_sequencer_if;
  logic pll_lock;
  logic pll_reset;
  logic pll_stdby;

  modport master (input pll_lock, output pll_reset, output pll_stdby);
  modport slave  (output pll_lock, input pll_reset, input pll_stdby);
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock/standby sequencer with debounce and retries
// Define PLLSEQ_LOCK_SYNC_EN to pass pll_lock through a 2-flop synchronizer.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_FILTER  = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               stdby_req,
  pll_lock_sequencer_if.master               pll,
  output logic                               locked,
  output logic                               lock_lost,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
);
  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int TOW = $clog2(LOCK_TIMEOUT + 1);
  localparam int LFW = $clog2(LOCK_FILTER + 1);
  localparam int RTW = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_STANDBY = 3'd4,
    ST_FAIL    = 3'd5
  } st_t;

  st_t            cur_st;
  st_t            nxt_st;
  logic           lock_s;
  logic [RCW-1:0] rst_tmr;
  logic [TOW-1:0] to_tmr;
  logic [LFW-1:0] filt_cnt;
  logic [RTW-1:0] retry_nxt;
  logic           rst_done;
  logic           to_done;
  logic           filt_done;
  logic           pll_reset_q;
  logic           pll_stdby_q;
  logic           pll_reset_d;
  logic           pll_stdby_d;
  logic           locked_d;
  logic           lock_lost_d;
  logic           fail_d;
  logic [RTW-1:0] retry_d;

`ifdef PLLSEQ_LOCK_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll.pll_lock};
  end

  assign lock_s = sync_q[1];
`else
  assign lock_s = pll.pll_lock;
`endif

  // Terminal counts are one short so each state occupies exactly its parameter in cycles.
  assign rst_done  = (rst_tmr == RCW'(RESET_CYCLES - 1));
  assign to_done   = (to_tmr == TOW'(LOCK_TIMEOUT - 1));
  assign filt_done = (filt_cnt == LFW'(LOCK_FILTER));
  assign retry_nxt = (retry_cnt == RTW'(MAX_RETRIES)) ? retry_cnt : retry_cnt + RTW'(1);

  assign pll.pll_reset = pll_reset_q;
  assign pll.pll_stdby = pll_stdby_q;
  assign state         = cur_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st      <= ST_IDLE;
      rst_tmr     <= '0;
      to_tmr      <= '0;
      filt_cnt    <= '0;
      pll_reset_q <= 1'b1;
      pll_stdby_q <= 1'b0;
      locked      <= 1'b0;
      lock_lost   <= 1'b0;
      fail        <= 1'b0;
      retry_cnt   <= '0;
    end else begin
      cur_st      <= nxt_st;
      rst_tmr     <= (cur_st == ST_RESET && nxt_st == ST_RESET) ?
                     rst_tmr + RCW'(!rst_done) : '0;
      to_tmr      <= (cur_st == ST_WAIT && nxt_st == ST_WAIT) ?
                     to_tmr + TOW'(!to_done) : '0;
      filt_cnt    <= (cur_st == ST_WAIT && nxt_st == ST_WAIT && lock_s) ?
                     filt_cnt + LFW'(!filt_done) : '0;
      pll_reset_q <= pll_reset_d;
      pll_stdby_q <= pll_stdby_d;
      locked      <= locked_d;
      lock_lost   <= lock_lost_d;
      fail        <= fail_d;
      retry_cnt   <= retry_d;
    end
  end

  always_comb begin
    nxt_st = cur_st;
    if (!en) begin
      nxt_st = ST_IDLE;
    end else begin
      case (cur_st)
        ST_IDLE:    nxt_st = ST_RESET;
        ST_RESET:   if (rst_done) nxt_st = ST_WAIT;
        ST_WAIT: begin
          if (filt_done)    nxt_st = ST_LOCKED;
          else if (to_done) nxt_st = (retry_nxt == RTW'(MAX_RETRIES)) ? ST_FAIL : ST_RESET;
        end
        ST_LOCKED: begin
          if (stdby_req)    nxt_st = ST_STANDBY;
          else if (!lock_s) nxt_st = ST_RESET;
        end
        ST_STANDBY: if (!stdby_req) nxt_st = ST_RESET;
        ST_FAIL:    nxt_st = ST_FAIL;
        default:    nxt_st = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values track state exactly.
  always_comb begin
    pll_reset_d = (nxt_st == ST_IDLE) || (nxt_st == ST_RESET) || (nxt_st == ST_FAIL);
    pll_stdby_d = (nxt_st == ST_STANDBY);
    locked_d    = (nxt_st == ST_LOCKED);
    fail_d      = (nxt_st == ST_FAIL);
    lock_lost_d = en && (cur_st == ST_LOCKED) && !stdby_req && !lock_s;
    retry_d     = retry_cnt;
    if (!en || nxt_st == ST_LOCKED)
      retry_d = '0;
    else if (cur_st == ST_WAIT && to_done)
      retry_d = retry_nxt;
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;
  logic       clk;
  logic       rst;
  logic       en;
  logic       stdby_req;
  logic       locked;
  logic       lock_lost;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] dut_state;
  int         checks;
  int         errors;

  pll_lock_sequencer_if pif ();

  pll_lock_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .stdby_req (stdby_req),
    .pll       (pif),
    .locked    (locked),
    .lock_lost (lock_lost),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .state     (dut_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (dut_state !== s && n < limit) begin
      tick();
      n++;
    end
    if (dut_state !== s) n = -1;
  endtask

  task automatic wait_leave(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (dut_state === s && n < limit) begin
      tick();
      n++;
    end
    if (dut_state === s) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; stdby_req = 1'b0; pif.pll_lock = 1'b0;
    repeat (3) tick();
    checks++; if (dut_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dut_state); end
    checks++; if (pif.pll_reset !== 1'b1) begin errors++; $display("FAIL reset_pll_reset: got %b want 1", pif.pll_reset); end
    checks++; if ({pif.pll_stdby, locked, lock_lost, fail} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pif.pll_stdby, locked, lock_lost, fail}); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
    rst = 1'b0;
    tick();
    checks++; if (dut_state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d want 0", dut_state); end
  endtask

  task automatic test_bringup();
    int n;
    en = 1'b1;
    tick();
    checks++; if (dut_state !== 3'd1 || pif.pll_reset !== 1'b1) begin errors++; $display("FAIL bringup_reset: got state %0d pll_reset %b want 1/1", dut_state, pif.pll_reset); end
    wait_leave(3'd1, 100, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL bringup_reset_len: got %0d want 16", n); end
    checks++; if (dut_state !== 3'd2 || pif.pll_reset !== 1'b0) begin errors++; $display("FAIL bringup_wait: got state %0d pll_reset %b want 2/0", dut_state, pif.pll_reset); end
    pif.pll_lock = 1'b1;
    wait_state(3'd3, 50, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL bringup_lock_latency: got %0d want 9", n); end
    checks++; if (locked !== 1'b1 || retry_cnt !== 2'd0 || pif.pll_reset !== 1'b0) begin errors++; $display("FAIL bringup_locked: got locked %b retry %0d pll_reset %b want 1/0/0", locked, retry_cnt, pif.pll_reset); end
  endtask

  task automatic test_lock_loss();
    int n;
    pif.pll_lock = 1'b0;
    tick();
    checks++; if (lock_lost !== 1'b1 || locked !== 1'b0 || dut_state !== 3'd1) begin errors++; $display("FAIL loss_pulse: got lost %b locked %b state %0d want 1/0/1", lock_lost, locked, dut_state); end
    pif.pll_lock = 1'b1;
    tick();
    checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL loss_width: got %b want 0", lock_lost); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL loss_no_retry: got %0d want 0", retry_cnt); end
    wait_state(3'd3, 100, n);
    checks++; if (n !== 24) begin errors++; $display("FAIL loss_relock: got %0d want 24", n); end
  endtask

  task automatic test_standby();
    int n;
    stdby_req = 1'b1; pif.pll_lock = 1'b0;
    tick();
    checks++; if (dut_state !== 3'd4 || pif.pll_stdby !== 1'b1) begin errors++; $display("FAIL stdby_enter: got state %0d stdby %b want 4/1", dut_state, pif.pll_stdby); end
    checks++; if (lock_lost !== 1'b0 || locked !== 1'b0 || pif.pll_reset !== 1'b0) begin errors++; $display("FAIL stdby_flags: got lost %b locked %b reset %b want 0/0/0", lock_lost, locked, pif.pll_reset); end
    for (int i = 0; i < 4; i++) begin
      pif.pll_lock = ~pif.pll_lock;
      tick();
    end
    checks++; if (dut_state !== 3'd4) begin errors++; $display("FAIL stdby_hold: got %0d want 4", dut_state); end
    stdby_req = 1'b0; pif.pll_lock = 1'b1;
    tick();
    checks++; if (dut_state !== 3'd1 || pif.pll_stdby !== 1'b0 || pif.pll_reset !== 1'b1) begin errors++; $display("FAIL stdby_exit: got state %0d stdby %b reset %b want 1/0/1", dut_state, pif.pll_stdby, pif.pll_reset); end
    wait_state(3'd3, 100, n);
    checks++; if (n !== 25) begin errors++; $display("FAIL stdby_relock: got %0d want 25", n); end
  endtask

  task automatic test_glitch();
    int n;
    int bad;
    bad = 0;
    pif.pll_lock = 1'b0;
    tick();
    wait_state(3'd2, 100, n);
    checks++; if (n !== 16) begin errors++; $display("FAIL glitch_reach_wait: got %0d want 16", n); end
    pif.pll_lock = 1'b1;
    repeat (7) begin
      tick();
      if (locked !== 1'b0) bad++;
    end
    pif.pll_lock = 1'b0;
    tick();
    if (locked !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_no_lock: got %0d locked cycles want 0", bad); end
    pif.pll_lock = 1'b1;
    wait_state(3'd3, 50, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL glitch_second_run: got %0d want 9", n); end
  endtask

  task automatic test_timeout();
    int n;
    en = 1'b0; pif.pll_lock = 1'b0;
    tick();
    checks++; if (dut_state !== 3'd0 || locked !== 1'b0 || pif.pll_reset !== 1'b1) begin errors++; $display("FAIL to_idle: got state %0d locked %b reset %b want 0/0/1", dut_state, locked, pif.pll_reset); end
    en = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      wait_state(3'd2, 100, n);
      checks++; if (n !== 16) begin errors++; $display("FAIL to_reset_len%0d: got %0d want 16", i, n); end
      wait_leave(3'd2, 2000, n);
      checks++; if (n !== 1024) begin errors++; $display("FAIL to_wait_len%0d: got %0d want 1024", i, n); end
      checks++; if (retry_cnt !== i[1:0]) begin errors++; $display("FAIL to_retry%0d: got %0d want %0d", i, retry_cnt, i); end
      checks++; if (dut_state !== ((i == 3) ? 3'd5 : 3'd1)) begin errors++; $display("FAIL to_next%0d: got %0d want %0d", i, dut_state, (i == 3) ? 5 : 1); end
    end
    repeat (5) tick();
    checks++; if (fail !== 1'b1 || pif.pll_reset !== 1'b1 || locked !== 1'b0 || dut_state !== 3'd5) begin errors++; $display("FAIL to_fail_hold: got fail %b reset %b locked %b state %0d want 1/1/0/5", fail, pif.pll_reset, locked, dut_state); end
    en = 1'b0;
    tick();
    checks++; if (dut_state !== 3'd0 || fail !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL to_clear: got state %0d fail %b retry %0d want 0/0/0", dut_state, fail, retry_cnt); end
  endtask

  task automatic test_async_reset();
    int n;
    en = 1'b1; pif.pll_lock = 1'b0;
    tick();
    wait_state(3'd2, 100, n);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dut_state !== 3'd0 || pif.pll_reset !== 1'b1) begin errors++; $display("FAIL arst_state: got state %0d reset %b want 0/1", dut_state, pif.pll_reset); end
    checks++; if ({pif.pll_stdby, locked, lock_lost, fail, retry_cnt} !== 6'd0) begin errors++; $display("FAIL arst_flags: got %b want 000000", {pif.pll_stdby, locked, lock_lost, fail, retry_cnt}); end
    #1;
    rst = 1'b0;
    pif.pll_lock = 1'b1;
    tick();
    checks++; if (dut_state !== 3'd1) begin errors++; $display("FAIL arst_restart: got %0d want 1", dut_state); end
    wait_state(3'd3, 100, n);
    checks++; if (n !== 25) begin errors++; $display("FAIL arst_relock: got %0d want 25", n); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bringup();
    test_lock_loss();
    test_standby();
    test_glitch();
    test_timeout();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
